// File: rtl/compare_sweeper.sv
// compare_sweeper: sweeps all (A,B) pairs through an external comparator,
// checks each answer against A<B and records the error count and first failing pair.
module compare_sweeper #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 2,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    input  logic               result,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_A,
    output logic [WIDTH-1:0]   fail_B
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SET_L = CW'(SETTLE - 1);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          golden;

    assign golden = (SIGNED != 0) ? ($signed(A) < $signed(B)) : (A < B);
    assign pass   = done && (err_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            A          <= '0;
            B          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_A     <= '0;
            fail_B     <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= DRIVE;
                    A          <= '0;
                    B          <= '0;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    err_count  <= '0;
                    fail_valid <= 1'b0;
                    fail_A     <= '0;
                    fail_B     <= '0;
                end
                DRIVE: begin
                    cnt   <= SET_L;
                    state <= (SETTLE == 1) ? CHECK : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CW'(1)) state <= CHECK;
                end
                CHECK: begin
                    if (result != golden) begin
                        if (!(&err_count)) err_count <= err_count + 1'b1;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_A     <= A;
                            fail_B     <= B;
                        end
                    end
                    // last pair holds on A/B so the final operands stay visible in DONE
                    if (&A && &B) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= DRIVE;
                        B     <= B + 1'b1;
                        if (&B) A <= A + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
